regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file, the next generation of the core's 8x8 register file. Sits between decode/issue and the ALU/load write-back stages. Adds:
- two write ports
- same-cycle write-to-read bypass
- per-register busy scoreboard for hazard detection
- raw debug read port
- registered write-conflict flag

Parameters:
WIDTH, 8, data width of every register
ADDR_W, 3, address width; register count NREGS = 2**ADDR_W
ZERO_REG, 1, 1: register 0 is hard-wired zero (writes/issues ignored, reads 0, never busy); 0: register 0 is ordinary
BYPASS, 1, 1: enabled same-cycle write data forwards to rs1/rs2 reads; 0: reads return stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rs1_addr  in  ADDR_W  read port 1 address
rs2_addr  in  ADDR_W  read port 2 address
rs1_data  out  WIDTH  read port 1 data (combinational)
rs2_data  out  WIDTH  read port 2 data (combinational)
rs1_busy  out  1  register at rs1_addr has an outstanding producer
rs2_busy  out  1  register at rs2_addr has an outstanding producer
wa_en  in  1  write port A enable (ALU write-back, higher priority)
wa_addr  in  ADDR_W  write port A address
wa_data  in  WIDTH  write port A data
wb_en  in  1  write port B enable (load write-back)
wb_addr  in  ADDR_W  write port B address
wb_data  in  WIDTH  write port B data
issue_en  in  1  mark a destination register busy
issue_addr  in  ADDR_W  destination being issued
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  WIDTH  stored value at dbg_addr (no bypass)
conflict  out  1  registered: A and B wrote the same effective address last cycle

Behaviour:
- Reset: synchronous, active-high, checked on the clk rising edge. Clears all NREGS registers to 0, all busy bits to 0 and conflict to 0. Reset overrides any write or issue in the same cycle.
- Effective write: port X writes when X_en=1, except that an address of 0 is ignored when ZERO_REG=1.
- Storage write, both ports to different addresses: both commit at the edge.
- Storage write, both ports to the same address: only wa_data commits (A wins). conflict <= 1 on the next edge; otherwise conflict <= 0.
- Reads, zero register: with ZERO_REG=1, address 0 always returns 0.
- Reads with BYPASS=1, priority order:
  1. effective A write to the same address -> wa_data
  2. else effective B write to the same address -> wb_data
  3. else stored value
- Reads with BYPASS=0: always the stored value; new data is visible the cycle after the write edge.
- dbg_data always returns raw storage (zero register reads 0 when ZERO_REG=1).
- Busy scoreboard: one bit per register.
  - Effective issue to addr N sets busy[N] at the edge.
  - Effective write by A or B to addr N clears busy[N] at the edge.
  - Issue and write to the same N in the same cycle: set wins (a new producer supersedes the old one).
  - Issue to 0 is ignored when ZERO_REG=1.
- Busy outputs: rsK_busy = busy[rsK_addr] AND NOT (an effective write to rsK_addr this cycle, when BYPASS=1). With BYPASS=0 it is busy[rsK_addr] only. Always 0 for address 0 when ZERO_REG=1.
- Latency: reads 0 cycles (combinational); writes, busy updates and conflict 1 cycle.
- No internal FSM beyond the storage and scoreboard state; everything is edge-synchronous to clk.

Test Plan:
1. Reset, then writes and reads (defaults). Assert rst for 1 cycle, then read all 8 addresses -> all data 0, busy 0, conflict 0. Write A: r3=0x5A. Next cycle rs1_addr=3 -> 0x5A, dbg_addr=3 -> 0x5A.
2. Zero register. Write wa_en=1, wa_addr=0, wa_data=0xFF and issue_addr=0 -> rs1_addr=0 returns 0, rs1_busy=0. With ZERO_REG=0, the same write makes r0 read 0xFF on the next cycle.
3. Bypass and conflict.
   - Same cycle: wb writes r5=0x11 while rs2_addr=5 -> rs2_data=0x11 that cycle; dbg_data(5) still shows the old value until the edge.
   - Both ports to r2 (A=0xAA, B=0xBB) -> rs1 reads 0xAA; stored r2=0xAA; conflict=1 for exactly one cycle.
4. Scoreboard.
   - issue r4 -> rs1_busy=1 from the next cycle.
   - wb writes r4=0x33 -> during that cycle rs1_busy=0 and rs1_data=0x33; next cycle busy=0.
   - issue r4 together with a wa write to r4 -> busy stays 1.
5. Reset mid-operation. With r1..r7 written and r6 busy, assert rst in the same cycle as a wa write to r6=0x77 -> after the edge r6=0, busy all 0, conflict 0.
6. BYPASS=0 build. Write r7=0x42 while rs1_addr=7 -> rs1_data shows the old value (0) that cycle and 0x42 the next cycle. rs1_busy reflects the stored busy bit only.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, write-to-read bypass, per-register
// busy scoreboard, raw debug read and a registered same-address write conflict flag.
module regfile_mp #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [WIDTH-1:0]  wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  output logic              conflict
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem_q [NREGS];
  logic [WIDTH-1:0]  mem_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              conflict_q, conflict_d;
  logic              wa_eff, wb_eff, iss_eff;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];
  logic              rd_busy [2];

  // Writes and issues to r0 are dropped when r0 is hard-wired zero
  always_comb begin
    wa_eff  = wa_en    && !(ZERO_REG && (wa_addr    == '0));
    wb_eff  = wb_en    && !(ZERO_REG && (wb_addr    == '0));
    iss_eff = issue_en && !(ZERO_REG && (issue_addr == '0));
  end

  // Next state: A applied after B so A wins a shared address; issue applied last so set wins
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wb_eff) begin
      mem_d[wb_addr]  = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    if (wa_eff) begin
      mem_d[wa_addr]  = wa_data;
      busy_d[wa_addr] = 1'b0;
    end
    if (iss_eff) begin
      busy_d[issue_addr] = 1'b1;
    end
    conflict_d = wa_eff && wb_eff && (wa_addr == wb_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  // Read ports: stored value, optionally overridden by this cycle's write (A before B)
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd_data[k] = mem_q[rd_addr[k]];
      rd_busy[k] = busy_q[rd_addr[k]];
      if (BYPASS) begin
        if (wa_eff && (wa_addr == rd_addr[k])) begin
          rd_data[k] = wa_data;
          rd_busy[k] = 1'b0;
        end else if (wb_eff && (wb_addr == rd_addr[k])) begin
          rd_data[k] = wb_data;
          rd_busy[k] = 1'b0;
        end
      end
      if (ZERO_REG && (rd_addr[k] == '0)) begin
        rd_data[k] = '0;
        rd_busy[k] = 1'b0;
      end
    end
  end

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];
  assign rs1_busy = rd_busy[0];
  assign rs2_busy = rd_busy[1];
  assign dbg_data = (ZERO_REG && (dbg_addr == '0)) ? '0 : mem_q[dbg_addr];
  assign conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, ZERO_REG=0 build and BYPASS=0 build
// share one stimulus; expected values go through a tag/value queue.
module tb_regfile_mp;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_addr, rs2_addr, wa_addr, wb_addr, issue_addr, dbg_addr;
  logic [W-1:0]  wa_data, wb_data;
  logic          wa_en, wb_en, issue_en;

  logic [W-1:0]  a_rs1, a_rs2, a_dbg, z_rs1, z_rs2, z_dbg, n_rs1, n_rs2, n_dbg;
  logic          a_b1, a_b2, a_cf, z_b1, z_b2, z_cf, n_b1, n_b2, n_cf;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_def (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(a_rs1), .rs2_data(a_rs2), .rs1_busy(a_b1), .rs2_busy(a_b2),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .dbg_addr(dbg_addr), .dbg_data(a_dbg), .conflict(a_cf));

  regfile_mp #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_nz (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(z_rs1), .rs2_data(z_rs2), .rs1_busy(z_b1), .rs2_busy(z_b2),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .dbg_addr(dbg_addr), .dbg_data(z_dbg), .conflict(z_cf));

  regfile_mp #(.WIDTH(W), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1), .rs2_data(n_rs2), .rs1_busy(n_b1), .rs2_busy(n_b2),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .dbg_addr(dbg_addr), .dbg_data(n_dbg), .conflict(n_cf));

  int           checks = 0;
  int           errors = 0;
  string        tag_q[$];
  logic [W-1:0] exp_q[$];

  task automatic want(input string tag, input logic [W-1:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic got(input logic [W-1:0] obs);
    string        t;
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h expected nothing", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wb_en = 1'b0; issue_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    wa_addr = '0; wb_addr = '0; issue_addr = '0; wa_data = '0; wb_data = '0;
    tick();
    rst = 1'b0;

    // Reset state across all addresses
    for (int i = 0; i < 8; i++) begin
      rs1_addr = AW'(i); rs2_addr = AW'(i); dbg_addr = AW'(i);
      want("rst_rs1", 8'h00); want("rst_rs2", 8'h00); want("rst_dbg", 8'h00);
      want("rst_busy", 8'h00); want("rst_nz_dbg", 8'h00);
      #2;
      got(a_rs1); got(a_rs2); got(a_dbg); got(8'({a_b1, a_b2})); got(z_dbg);
    end
    want("rst_conflict", 8'h00);
    got(8'(a_cf));

    // Basic write via A
    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 8'h5A;
    tick(); idle();
    rs1_addr = 3'd3; dbg_addr = 3'd3;
    want("w_r3_rs1", 8'h5A); want("w_r3_dbg", 8'h5A); want("w_r3_nb_rs1", 8'h5A);
    #2; got(a_rs1); got(a_dbg); got(n_rs1);

    // Zero register: write + issue to r0
    wa_en = 1'b1; wa_addr = 3'd0; wa_data = 8'hFF; issue_en = 1'b1; issue_addr = 3'd0;
    rs1_addr = 3'd0; dbg_addr = 3'd0;
    want("z0_rs1", 8'h00); want("z0_busy", 8'h00); want("nz0_bypass", 8'hFF);
    #2; got(a_rs1); got(8'(a_b1)); got(z_rs1);
    tick(); idle();
    want("z0_rs1_next", 8'h00); want("z0_dbg", 8'h00); want("z0_busy_next", 8'h00);
    want("nz0_rs1_next", 8'hFF); want("nz0_dbg", 8'hFF); want("nz0_busy_set", 8'h01);
    #2; got(a_rs1); got(a_dbg); got(8'(a_b1)); got(z_rs1); got(z_dbg); got(8'(z_b1));

    // B bypass vs stored value
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'h11; rs2_addr = 3'd5; dbg_addr = 3'd5;
    want("byp_b_rs2", 8'h11); want("byp_b_dbg_old", 8'h00); want("nb_rs2_old", 8'h00);
    #2; got(a_rs2); got(a_dbg); got(n_rs2);
    tick(); idle();
    want("byp_b_dbg_new", 8'h11); want("nb_rs2_new", 8'h11);
    #2; got(a_dbg); got(n_rs2);

    // Both ports to r2: A wins, conflict for one cycle
    wa_en = 1'b1; wa_addr = 3'd2; wa_data = 8'hAA;
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'hBB;
    rs1_addr = 3'd2; rs2_addr = 3'd2; dbg_addr = 3'd2;
    want("cf_rs1_a", 8'hAA); want("cf_rs2_a", 8'hAA); want("cf_dbg_old", 8'h00);
    want("cf_before", 8'h00);
    #2; got(a_rs1); got(a_rs2); got(a_dbg); got(8'(a_cf));
    tick(); idle();
    want("cf_set", 8'h01); want("cf_dbg_a", 8'hAA); want("cf_nb_rs1", 8'hAA);
    want("cf_nz_set", 8'h01);
    #2; got(8'(a_cf)); got(a_dbg); got(n_rs1); got(8'(z_cf));
    tick();
    want("cf_clear", 8'h00);
    #2; got(8'(a_cf));

    // Different addresses on A and B both commit
    wa_en = 1'b1; wa_addr = 3'd1; wa_data = 8'h01;
    wb_en = 1'b1; wb_addr = 3'd6; wb_data = 8'h06;
    rs1_addr = 3'd1; rs2_addr = 3'd6;
    want("dual_rs1", 8'h01); want("dual_rs2", 8'h06); want("dual_nb_rs2", 8'h00);
    #2; got(a_rs1); got(a_rs2); got(n_rs2);
    tick(); idle();
    dbg_addr = 3'd1;
    want("dual_dbg1", 8'h01); want("dual_rs2_st", 8'h06); want("dual_nocf", 8'h00);
    #2; got(a_dbg); got(a_rs2); got(8'(a_cf));

    // Scoreboard
    issue_en = 1'b1; issue_addr = 3'd4; rs1_addr = 3'd4;
    want("sb_issue_same", 8'h00);
    #2; got(8'(a_b1));
    tick(); idle();
    want("sb_busy", 8'h01); want("sb_nb_busy", 8'h01);
    #2; got(8'(a_b1)); got(8'(n_b1));
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h33;
    want("sb_wr_busy", 8'h00); want("sb_wr_data", 8'h33);
    want("sb_nb_wr_busy", 8'h01); want("sb_nb_wr_data", 8'h00);
    #2; got(8'(a_b1)); got(a_rs1); got(8'(n_b1)); got(n_rs1);
    tick(); idle();
    want("sb_cleared", 8'h00); want("sb_nb_cleared", 8'h00); want("sb_nb_data", 8'h33);
    #2; got(8'(a_b1)); got(8'(n_b1)); got(n_rs1);
    issue_en = 1'b1; issue_addr = 3'd4; wa_en = 1'b1; wa_addr = 3'd4; wa_data = 8'h44;
    want("sb_iw_busy", 8'h00); want("sb_iw_data", 8'h44);
    #2; got(8'(a_b1)); got(a_rs1);
    tick(); idle();
    want("sb_setwins", 8'h01); want("sb_setwins_data", 8'h44); want("sb_nb_setwins", 8'h01);
    #2; got(8'(a_b1)); got(a_rs1); got(8'(n_b1));

    // Reset mid-operation
    wa_en = 1'b1; wa_addr = 3'd7; wa_data = 8'h07; issue_en = 1'b1; issue_addr = 3'd6;
    tick(); idle();
    dbg_addr = 3'd6; rs2_addr = 3'd6;
    want("pre_rst_dbg6", 8'h06); want("pre_rst_busy6", 8'h01);
    #2; got(a_dbg); got(8'(a_b2));
    rst = 1'b1;
    wa_en = 1'b1; wa_addr = 3'd6; wa_data = 8'h77;
    wb_en = 1'b1; wb_addr = 3'd6; wb_data = 8'h88;
    issue_en = 1'b1; issue_addr = 3'd3;
    tick(); rst = 1'b0; idle();
    rs1_addr = 3'd4; rs2_addr = 3'd6; dbg_addr = 3'd6;
    want("mrst_dbg6", 8'h00); want("mrst_busy6", 8'h00); want("mrst_cf", 8'h00);
    want("mrst_busy4", 8'h00); want("mrst_r4", 8'h00); want("mrst_nb_busy4", 8'h00);
    #2; got(a_dbg); got(8'(a_b2)); got(8'(a_cf)); got(8'(a_b1)); got(a_rs1); got(8'(n_b1));
    rs1_addr = 3'd3; dbg_addr = 3'd7;
    want("mrst_busy3", 8'h00); want("mrst_dbg7", 8'h00);
    #2; got(8'(a_b1)); got(a_dbg);

    // BYPASS=0 build: data and busy follow storage only
    wa_en = 1'b1; wa_addr = 3'd7; wa_data = 8'h42; rs1_addr = 3'd7;
    want("nb_old", 8'h00); want("byp_new", 8'h42);
    #2; got(n_rs1); got(a_rs1);
    tick(); idle();
    want("nb_next", 8'h42);
    #2; got(n_rs1);
    issue_en = 1'b1; issue_addr = 3'd7;
    tick(); idle();
    wb_en = 1'b1; wb_addr = 3'd7; wb_data = 8'h55;
    want("nb_busy_stored", 8'h01); want("byp_busy_masked", 8'h00); want("nb_data_stored", 8'h42);
    #2; got(8'(n_b1)); got(8'(a_b1)); got(n_rs1);
    tick(); idle();
    want("nb_busy_clr", 8'h00); want("nb_data_55", 8'h55);
    #2; got(8'(n_b1)); got(n_rs1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
